// File: rtl/sonar_sweep_uc_pkg.sv
// Shared definitions for the sonar sweep control unit: state codes,
// sweep direction and the timer sizing helper.
package sonar_sweep_uc_pkg;

  // State codes, also shown on the debug display as {1'b0, code}
  typedef enum logic [2:0] {
    INICIAL       = 3'd0,
    PREPARACAO    = 3'd1,
    ENVIA_TRIGGER = 3'd2,
    ESPERA_MEDIDA = 3'd3,
    REGISTRA      = 3'd4,
    ESPERA_TIMER  = 3'd5,
    GIRA_SERVO    = 3'd6,
    FINAL_POSICAO = 3'd7
  } estado_t;

  // Sweep direction of the servo position counter
  typedef enum logic {
    SOBE  = 1'b0,
    DESCE = 1'b1
  } sentido_t;

  localparam int DB_ESTADO_W = 4;

  function automatic int maxInt(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // One spare bit above what the longer of the two waits needs
  function automatic int timerWidth(input int waitCycles, input int timeoutCycles);
    return $clog2(maxInt(waitCycles, timeoutCycles)) + 1;
  endfunction

endpackage

// File: rtl/sonar_sweep_uc_contador.sv
// Ping-pong position counter: walks 0 -> N_POS-1 -> 0 and flags each
// reversal at the ends. Position and direction survive idle periods.
module sonar_contador_posicao
  import sonar_sweep_uc_pkg::*;
#(
  parameter int N_POS = 8,
  parameter int POS_W = 3
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             conta,
  output logic [POS_W-1:0] posicao,
  output logic             fim_varredura
);

  localparam logic [POS_W-1:0] POS_TOPO   = POS_W'(N_POS - 1);
  localparam logic [POS_W-1:0] POS_PENULT = POS_W'(N_POS - 2);
  localparam logic [POS_W-1:0] POS_UM     = POS_W'(1);

  logic [POS_W-1:0] pos_q, pos_d;
  sentido_t         sentido_q, sentido_d;
  logic             reverte;

  // Next position: bounce off either end, otherwise step in the current direction
  always_comb begin
    pos_d     = pos_q;
    sentido_d = sentido_q;
    reverte   = 1'b0;
    if (conta) begin
      if (sentido_q == SOBE && pos_q == POS_TOPO) begin
        sentido_d = DESCE;
        pos_d     = POS_PENULT;
        reverte   = 1'b1;
      end else if (sentido_q == DESCE && pos_q == '0) begin
        sentido_d = SOBE;
        pos_d     = POS_UM;
        reverte   = 1'b1;
      end else if (sentido_q == SOBE) begin
        pos_d = pos_q + POS_UM;
      end else begin
        pos_d = pos_q - POS_UM;
      end
    end
  end

  // Position and direction registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pos_q     <= '0;
      sentido_q <= SOBE;
    end else begin
      pos_q     <= pos_d;
      sentido_q <= sentido_d;
    end
  end

  assign posicao       = pos_q;
  assign fim_varredura = reverte;

endmodule

// File: rtl/sonar_sweep_uc.sv
// Sonar sweep control unit: per servo position it triggers one ranging
// measurement, waits for the result or a timeout, waits a settling time,
// then moves the servo. Single-step or continuous with a latched stop.
module sonar_sweep_uc
  import sonar_sweep_uc_pkg::*;
#(
  parameter int N_POS          = 8,
  parameter int POS_W          = 3,
  parameter int WAIT_CYCLES    = 100000000,
  parameter int TIMEOUT_CYCLES = 2500000
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   mensurar,
  input  logic                   modo,
  input  logic                   parar,
  input  logic                   pronto_medida,
  output logic                   inicio_medir,
  output logic                   move_servo,
  output logic                   medida_valida,
  output logic                   fim_varredura,
  output logic                   erro_timeout,
  output logic [POS_W-1:0]       posicao,
  output logic [DB_ESTADO_W-1:0] db_estado
);

  localparam int TIMER_W = timerWidth(WAIT_CYCLES, TIMEOUT_CYCLES);
  localparam logic [TIMER_W-1:0] WAIT_LAST    = TIMER_W'(WAIT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMER_UM     = TIMER_W'(1);

  estado_t            estado_q;
  logic [TIMER_W-1:0] timer_q;
  logic               erro_q;
  logic               parar_q;
  logic               conta;

  // Main FSM with its timer, sticky timeout flag and stop latch
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_q <= INICIAL;
      timer_q  <= '0;
      erro_q   <= 1'b0;
      parar_q  <= 1'b0;
    end else begin
      if (parar && estado_q != INICIAL) begin
        parar_q <= 1'b1;
      end
      case (estado_q)
        INICIAL: begin
          if (mensurar) begin
            erro_q   <= 1'b0;
            estado_q <= PREPARACAO;
          end
        end
        PREPARACAO: begin
          timer_q  <= '0;
          estado_q <= ENVIA_TRIGGER;
        end
        ENVIA_TRIGGER: begin
          estado_q <= ESPERA_MEDIDA;
        end
        ESPERA_MEDIDA: begin
          if (pronto_medida) begin
            estado_q <= REGISTRA;
          end else if (timer_q == TIMEOUT_LAST) begin
            erro_q   <= 1'b1;
            timer_q  <= '0;
            estado_q <= ESPERA_TIMER;
          end else begin
            timer_q <= timer_q + TIMER_UM;
          end
        end
        REGISTRA: begin
          timer_q  <= '0;
          estado_q <= ESPERA_TIMER;
        end
        ESPERA_TIMER: begin
          if (timer_q == WAIT_LAST) begin
            estado_q <= GIRA_SERVO;
          end else begin
            timer_q <= timer_q + TIMER_UM;
          end
        end
        GIRA_SERVO: begin
          estado_q <= FINAL_POSICAO;
        end
        FINAL_POSICAO: begin
          if (modo && !parar_q) begin
            estado_q <= PREPARACAO;
          end else begin
            parar_q  <= 1'b0;
            estado_q <= INICIAL;
          end
        end
        default: begin
          parar_q  <= 1'b0;
          estado_q <= INICIAL;
        end
      endcase
    end
  end

  // Moore outputs decoded from the state register only
  always_comb begin
    inicio_medir  = 1'b0;
    medida_valida = 1'b0;
    conta         = 1'b0;
    case (estado_q)
      ENVIA_TRIGGER: inicio_medir  = 1'b1;
      REGISTRA:      medida_valida = 1'b1;
      GIRA_SERVO:    conta         = 1'b1;
      default:       ;
    endcase
  end

  sonar_contador_posicao #(
    .N_POS (N_POS),
    .POS_W (POS_W)
  ) u_contador (
    .clock         (clock),
    .reset_n       (reset_n),
    .conta         (conta),
    .posicao       (posicao),
    .fim_varredura (fim_varredura)
  );

  assign move_servo   = conta;
  assign erro_timeout = erro_q;
  assign db_estado    = {1'b0, estado_q};

endmodule

// File: tb/tb_sonar_sweep_uc.sv
// Directed bench for sonar_sweep_uc with N_POS=4, POS_W=2, WAIT_CYCLES=5,
// TIMEOUT_CYCLES=8. Outputs are sampled 1 time unit after each rising edge.
module tb_sonar_sweep_uc;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       mensurar;
  logic       modo;
  logic       parar;
  logic       pronto_medida;
  logic       inicio_medir;
  logic       move_servo;
  logic       medida_valida;
  logic       fim_varredura;
  logic       erro_timeout;
  logic [1:0] posicao;
  logic [3:0] db_estado;

  int total = 0;
  int bad   = 0;
  int cnt;
  int expPos[6] = '{2, 3, 2, 1, 0, 1};
  int expFim[6] = '{0, 0, 1, 0, 0, 1};

  always #5 clock = ~clock;

  sonar_sweep_uc #(
    .N_POS          (4),
    .POS_W          (2),
    .WAIT_CYCLES    (5),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .mensurar      (mensurar),
    .modo          (modo),
    .parar         (parar),
    .pronto_medida (pronto_medida),
    .inicio_medir  (inicio_medir),
    .move_servo    (move_servo),
    .medida_valida (medida_valida),
    .fim_varredura (fim_varredura),
    .erro_timeout  (erro_timeout),
    .posicao       (posicao),
    .db_estado     (db_estado)
  );

  task automatic tickClock();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic m, input logic md, input logic p, input logic pr);
    mensurar      = m;
    modo          = md;
    parar         = p;
    pronto_medida = pr;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // pulses = {inicio_medir, move_servo, medida_valida, fim_varredura}
  task automatic checkAllOutputs(input string tag, input logic [3:0] db, input logic [1:0] pos,
                                 input logic [3:0] pulses, input logic erro);
    logic [10:0] obs;
    logic [10:0] exp;
    obs = {db_estado, posicao, inicio_medir, move_servo, medida_valida, fim_varredura, erro_timeout};
    exp = {db, pos, pulses, erro};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%b expected=%b (db,pos,ini,mov,val,fim,err)", tag, obs, exp);
    end
  endtask

  task automatic waitState(input string tag, input logic [3:0] code, input int budget);
    for (int k = 0; k < budget && db_estado != code; k++) tickClock();
    checkOutput(tag, {28'd0, db_estado}, {28'd0, code});
  endtask

  initial begin
    #50000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset_n = 1'b0;
    applyStimulus(0, 0, 0, 0);
    repeat (2) tickClock();
    checkAllOutputs("reset state", 4'd0, 2'd0, 4'b0000, 1'b0);
    reset_n = 1'b1;

    // Single-step position, pronto three cycles after the trigger
    applyStimulus(1, 0, 0, 0);
    tickClock();
    checkAllOutputs("t2 preparacao", 4'd1, 2'd0, 4'b0000, 1'b0);
    applyStimulus(0, 0, 0, 0);
    tickClock();
    checkAllOutputs("t2 trigger", 4'd2, 2'd0, 4'b1000, 1'b0);
    tickClock();
    checkAllOutputs("t2 espera c1", 4'd3, 2'd0, 4'b0000, 1'b0);
    tickClock();
    checkAllOutputs("t2 espera c2", 4'd3, 2'd0, 4'b0000, 1'b0);
    tickClock();
    checkAllOutputs("t2 espera c3", 4'd3, 2'd0, 4'b0000, 1'b0);
    applyStimulus(0, 0, 0, 1);
    tickClock();
    checkAllOutputs("t2 registra", 4'd4, 2'd0, 4'b0010, 1'b0);
    applyStimulus(0, 0, 0, 0);
    tickClock();
    checkAllOutputs("t2 espera timer", 4'd5, 2'd0, 4'b0000, 1'b0);
    cnt = 0;
    while (db_estado == 4'd5 && cnt < 20) begin
      cnt++;
      tickClock();
    end
    checkOutput("t2 settle cycles", cnt, 5);
    checkAllOutputs("t2 gira", 4'd6, 2'd0, 4'b0100, 1'b0);
    tickClock();
    checkAllOutputs("t2 final", 4'd7, 2'd1, 4'b0000, 1'b0);
    tickClock();
    checkAllOutputs("t2 back idle", 4'd0, 2'd1, 4'b0000, 1'b0);
    tickClock();
    checkAllOutputs("t2 stays idle", 4'd0, 2'd1, 4'b0000, 1'b0);

    // Continuous sweep 1,2,3,2,1,0,1 with stop on the last position
    applyStimulus(1, 1, 0, 1);
    tickClock();
    applyStimulus(0, 1, 0, 1);
    for (int i = 0; i < 6; i++) begin
      waitState("t3 wait gira", 4'd6, 40);
      checkOutput("t3 move", move_servo, 1);
      checkOutput("t3 fim", fim_varredura, expFim[i]);
      if (i == 5) applyStimulus(0, 1, 1, 1);
      tickClock();
      applyStimulus(0, 1, 0, 1);
      checkOutput("t3 posicao", posicao, expPos[i]);
    end
    tickClock();
    checkAllOutputs("t3 stopped", 4'd0, 2'd1, 4'b0000, 1'b0);
    applyStimulus(0, 0, 0, 0);

    // Timeout: no pronto at all
    applyStimulus(1, 0, 0, 0);
    tickClock();
    applyStimulus(0, 0, 0, 0);
    tickClock();
    tickClock();
    checkAllOutputs("t4 espera t0", 4'd3, 2'd1, 4'b0000, 1'b0);
    repeat (7) tickClock();
    checkAllOutputs("t4 espera t7", 4'd3, 2'd1, 4'b0000, 1'b0);
    tickClock();
    checkAllOutputs("t4 timeout", 4'd5, 2'd1, 4'b0000, 1'b1);
    waitState("t4 wait gira", 4'd6, 20);
    checkAllOutputs("t4 gira", 4'd6, 2'd1, 4'b0100, 1'b1);
    tickClock();
    tickClock();
    checkAllOutputs("t4 idle sticky", 4'd0, 2'd2, 4'b0000, 1'b1);

    // pronto in the same cycle as the timeout
    applyStimulus(1, 0, 0, 0);
    tickClock();
    checkAllOutputs("t5 erro cleared", 4'd1, 2'd2, 4'b0000, 1'b0);
    applyStimulus(0, 0, 0, 0);
    tickClock();
    tickClock();
    repeat (7) tickClock();
    checkAllOutputs("t5 espera t7", 4'd3, 2'd2, 4'b0000, 1'b0);
    applyStimulus(0, 0, 0, 1);
    tickClock();
    checkAllOutputs("t5 registra", 4'd4, 2'd2, 4'b0010, 1'b0);
    applyStimulus(0, 0, 0, 0);
    waitState("t5 wait idle", 4'd0, 30);
    checkAllOutputs("t5 idle", 4'd0, 2'd3, 4'b0000, 1'b0);

    // Stop during ESPERA_MEDIDA in continuous mode, then resume
    applyStimulus(1, 1, 0, 0);
    tickClock();
    applyStimulus(0, 1, 0, 0);
    tickClock();
    tickClock();
    checkAllOutputs("t6 espera", 4'd3, 2'd3, 4'b0000, 1'b0);
    applyStimulus(0, 1, 1, 0);
    tickClock();
    applyStimulus(0, 1, 0, 1);
    tickClock();
    checkAllOutputs("t6 registra", 4'd4, 2'd3, 4'b0010, 1'b0);
    applyStimulus(0, 1, 0, 0);
    waitState("t6 wait gira", 4'd6, 20);
    checkAllOutputs("t6 gira top", 4'd6, 2'd3, 4'b0101, 1'b0);
    tickClock();
    checkAllOutputs("t6 final", 4'd7, 2'd2, 4'b0000, 1'b0);
    tickClock();
    checkAllOutputs("t6 stopped", 4'd0, 2'd2, 4'b0000, 1'b0);
    tickClock();
    checkAllOutputs("t6 holds idle", 4'd0, 2'd2, 4'b0000, 1'b0);
    applyStimulus(1, 0, 0, 1);
    tickClock();
    applyStimulus(0, 0, 0, 1);
    waitState("t6 resume reg", 4'd4, 10);
    applyStimulus(0, 0, 0, 0);
    waitState("t6 resume gira", 4'd6, 20);
    checkAllOutputs("t6 resume gira", 4'd6, 2'd2, 4'b0100, 1'b0);
    tickClock();
    checkAllOutputs("t6 resume down", 4'd7, 2'd1, 4'b0000, 1'b0);
    tickClock();

    // Asynchronous reset in the middle of ESPERA_TIMER
    applyStimulus(1, 0, 0, 1);
    tickClock();
    applyStimulus(0, 0, 0, 1);
    waitState("t1 wait timer", 4'd5, 20);
    applyStimulus(0, 0, 0, 0);
    tickClock();
    tickClock();
    checkAllOutputs("t1 before reset", 4'd5, 2'd1, 4'b0000, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    checkAllOutputs("t1 reset immediate", 4'd0, 2'd0, 4'b0000, 1'b0);
    repeat (2) tickClock();
    checkAllOutputs("t1 reset held", 4'd0, 2'd0, 4'b0000, 1'b0);
    reset_n = 1'b1;
    tickClock();
    checkAllOutputs("t1 after release", 4'd0, 2'd0, 4'b0000, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
